// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the hazard/stall controller and its forwarding unit.
package hazard_stall_controller_pkg;

    typedef enum logic {
        RUN,
        STALL
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // EX/MEM wins over MEM/WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit) begin
            return FWD_MEM;
        end else if (wb_hit) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_stall_controller_forwarding_unit.sv
// Combinational EX operand-select logic; only instantiated when FORWARDING_EN is defined.
module forwarding_unit
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned RegAddrW = 5
) (
    input  logic [RegAddrW-1:0] ex_rs_i,
    input  logic [RegAddrW-1:0] ex_rt_i,
    input  logic                mem_reg_write_i,
    input  logic [RegAddrW-1:0] mem_write_reg_i,
    input  logic                wb_reg_write_i,
    input  logic [RegAddrW-1:0] wb_write_reg_i,
    output logic [1:0]          forward_a_o,
    output logic [1:0]          forward_b_o
);

    function automatic logic hit(input logic we, input logic [RegAddrW-1:0] dst,
                                 input logic [RegAddrW-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

    assign forward_a_o = fwd_sel(hit(mem_reg_write_i, mem_write_reg_i, ex_rs_i),
                                 hit(wb_reg_write_i, wb_write_reg_i, ex_rs_i));
    assign forward_b_o = fwd_sel(hit(mem_reg_write_i, mem_write_reg_i, ex_rt_i),
                                 hit(wb_reg_write_i, wb_write_reg_i, ex_rt_i));

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall controller with saturating stall counter.
// Define FORWARDING_EN to compile in the forwarding unit (shorter load-use stalls only).
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rs,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rs,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_write_reg,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_write_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_write_reg,
    input  logic                  ex_branch_taken,
    input  logic                  ex_jump,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            forward_a,
    output logic [1:0]            forward_b,
    output logic                  stalling,
    output logic [CNT_W-1:0]      stall_cycles
);

    function automatic logic hit(input logic we, input logic [REG_ADDR_W-1:0] dst,
                                 input logic [REG_ADDR_W-1:0] src, input logic uses);
        return we && (dst != '0) && (dst == src) && uses;
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [1:0]       need;
    logic             ex_hit;
    logic             transfer;

    assign ex_hit   = hit(ex_reg_write, ex_write_reg, id_rs, id_uses_rs) |
                      hit(ex_reg_write, ex_write_reg, id_rt, id_uses_rt);
    assign transfer = ex_branch_taken | ex_jump;

`ifdef FORWARDING_EN
    assign need = (ex_mem_read && ex_hit) ? 2'd1 : 2'd0;

    forwarding_unit #(
        .RegAddrW (REG_ADDR_W)
    ) u_forwarding_unit (
        .ex_rs_i         (ex_rs),
        .ex_rt_i         (ex_rt),
        .mem_reg_write_i (mem_reg_write),
        .mem_write_reg_i (mem_write_reg),
        .wb_reg_write_i  (wb_reg_write),
        .wb_write_reg_i  (wb_write_reg),
        .forward_a_o     (forward_a),
        .forward_b_o     (forward_b)
    );
`else
    logic mem_hit;
    logic unused_fwd_inputs;

    // Register file writes before it reads, so a WB-stage producer needs no stall.
    assign mem_hit = hit(mem_reg_write, mem_write_reg, id_rs, id_uses_rs) |
                     hit(mem_reg_write, mem_write_reg, id_rt, id_uses_rt);
    assign need    = ex_hit ? 2'd2 : (mem_hit ? 2'd1 : 2'd0);

    assign forward_a = FWD_RF;
    assign forward_b = FWD_RF;
    assign unused_fwd_inputs = ^{ex_rs, ex_rt, ex_mem_read, wb_reg_write, wb_write_reg};
`endif

    always_comb begin
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        state_d        = state_q;
        cnt_d          = cnt_q;
        if (transfer) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            state_d      = RUN;
            cnt_d        = 2'd0;
        end else if (state_q == STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            cnt_d        = cnt_q - 2'd1;
            if (cnt_q <= 2'd1) begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        end else if (need != 2'd0) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (need == 2'd2) begin
                state_d = STALL;
                cnt_d   = 2'd1;
            end
        end
        stall_cycles_d = stall_cycles_q;
        if (!pc_write && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stalling     = (state_q == STALL);
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller; follows FORWARDING_EN like the RTL.
module tb_hazard_stall_controller;

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 3;

    typedef struct packed {
        logic [AW-1:0] id_rs;
        logic [AW-1:0] id_rt;
        logic          urs;
        logic          urt;
        logic [AW-1:0] ex_rs;
        logic [AW-1:0] ex_rt;
        logic          ex_rw;
        logic          ex_mr;
        logic [AW-1:0] ex_wr;
        logic          mem_rw;
        logic [AW-1:0] mem_wr;
        logic          wb_rw;
        logic [AW-1:0] wb_wr;
        logic          br;
        logic          jmp;
    } in_t;

    typedef struct packed {
        logic       pc;
        logic       ifid;
        logic       flush;
        logic       bubble;
        logic       stalling;
        logic [1:0] fa;
        logic [1:0] fb;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp_nf;
        out_t  exp_fw;
    } vec_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    logic          clk;
    logic          reset;
    logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_write_reg, mem_write_reg, wb_write_reg;
    logic          id_uses_rs, id_uses_rt, ex_reg_write, ex_mem_read;
    logic          mem_reg_write, wb_reg_write, ex_branch_taken, ex_jump;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, stalling;
    logic [1:0]    forward_a, forward_b;
    logic [CW-1:0] stall_cycles;

    int   n_tests = 0;
    int   n_fail  = 0;
    sb_t  sb_q[$];
    vec_t vecs[12];

    hazard_stall_controller #(
        .REG_ADDR_W (AW),
        .CNT_W      (CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .ex_rs           (ex_rs),
        .ex_rt           (ex_rt),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_write_reg    (ex_write_reg),
        .mem_reg_write   (mem_reg_write),
        .mem_write_reg   (mem_write_reg),
        .wb_reg_write    (wb_reg_write),
        .wb_write_reg    (wb_write_reg),
        .ex_branch_taken (ex_branch_taken),
        .ex_jump         (ex_jump),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .forward_a       (forward_a),
        .forward_b       (forward_b),
        .stalling        (stalling),
        .stall_cycles    (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mkin(int rs, int rt, int urs, int urt, int xrs, int xrt,
                                 int xrw, int xmr, int xwr, int mrw, int mwr,
                                 int wrw, int wwr, int br, int jmp);
        in_t v;
        v.id_rs  = AW'(rs);   v.id_rt  = AW'(rt);
        v.urs    = 1'(urs);   v.urt    = 1'(urt);
        v.ex_rs  = AW'(xrs);  v.ex_rt  = AW'(xrt);
        v.ex_rw  = 1'(xrw);   v.ex_mr  = 1'(xmr);   v.ex_wr  = AW'(xwr);
        v.mem_rw = 1'(mrw);   v.mem_wr = AW'(mwr);
        v.wb_rw  = 1'(wrw);   v.wb_wr  = AW'(wwr);
        v.br     = 1'(br);    v.jmp    = 1'(jmp);
        return v;
    endfunction

    // ifid always follows pc_write in this design's contract.
    function automatic out_t mk(int pc, int fl, int bu, int st, int fa, int fb);
        out_t o;
        o.pc = 1'(pc); o.ifid = 1'(pc); o.flush = 1'(fl); o.bubble = 1'(bu);
        o.stalling = 1'(st); o.fa = 2'(fa); o.fb = 2'(fb);
        return o;
    endfunction

    task automatic apply(input in_t v);
        id_rs = v.id_rs; id_rt = v.id_rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
        ex_rs = v.ex_rs; ex_rt = v.ex_rt; ex_reg_write = v.ex_rw; ex_mem_read = v.ex_mr;
        ex_write_reg = v.ex_wr; mem_reg_write = v.mem_rw; mem_write_reg = v.mem_wr;
        wb_reg_write = v.wb_rw; wb_write_reg = v.wb_wr;
        ex_branch_taken = v.br; ex_jump = v.jmp;
    endtask

    task automatic step(input string name, input in_t v, input out_t e);
        sb_t  s;
        out_t act;
        apply(v);
        sb_q.push_back('{name: name, exp: e});
        @(negedge clk);
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, stalling, forward_a, forward_b};
        n_tests++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", name, act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                n_fail++;
                $display("FAIL %s: {pc,ifid,flush,bubble,stall,fa,fb} got %b expected %b",
                         s.name, act, s.exp);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input int e);
        n_tests++;
        if (stall_cycles !== CW'(e)) begin
            n_fail++;
            $display("FAIL %s: stall_cycles got %0d expected %0d", name, stall_cycles, e);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply('0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        in_t  idle;
        in_t  haz;
        in_t  haz_br;
        idle = '0;
`ifdef FORWARDING_EN
        haz = mkin(8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 0);
`else
        haz = mkin(0, 9, 0, 1, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0);
`endif
        haz_br = haz;
        haz_br.br = 1'b1;

        vecs[0]  = '{"idle",       mkin(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,0,0)};
        vecs[1]  = '{"load_use",   mkin(8,0,1,0, 0,0, 1,1,8, 0,0, 0,0, 0,0),
                     mk(0,0,1,0,0,0), mk(0,0,1,0,0,0)};
        vecs[2]  = '{"raw_ex",     mkin(0,9,0,1, 0,0, 1,0,9, 0,0, 0,0, 0,0),
                     mk(0,0,1,0,0,0), mk(1,0,0,0,0,0)};
        vecs[3]  = '{"raw_mem",    mkin(3,0,1,0, 3,0, 0,0,0, 1,3, 0,0, 0,0),
                     mk(0,0,1,0,0,0), mk(1,0,0,0,2,0)};
        vecs[4]  = '{"src_unused", mkin(4,0,0,0, 0,0, 1,0,4, 0,0, 0,0, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,0,0)};
        vecs[5]  = '{"reg_zero",   mkin(0,0,1,1, 0,0, 1,1,0, 1,0, 1,0, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,0,0)};
        vecs[6]  = '{"fwd_prio",   mkin(0,0,0,0, 5,0, 0,0,0, 1,5, 1,5, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,2,0)};
        vecs[7]  = '{"fwd_wb",     mkin(0,0,0,0, 5,0, 0,0,0, 0,5, 1,5, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,1,0)};
        vecs[8]  = '{"fwd_b",      mkin(0,0,0,0, 0,7, 0,0,0, 1,6, 1,7, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,0,1)};
        vecs[9]  = '{"br_and_haz", mkin(8,0,1,0, 0,0, 1,1,8, 0,0, 0,0, 1,0),
                     mk(1,1,1,0,0,0), mk(1,1,1,0,0,0)};
        vecs[10] = '{"jump",       mkin(0,0,0,0, 0,0, 0,0,0, 0,0, 0,0, 0,1),
                     mk(1,1,1,0,0,0), mk(1,1,1,0,0,0)};
        vecs[11] = '{"no_we",      mkin(8,0,1,0, 0,0, 0,1,8, 0,0, 0,0, 0,0),
                     mk(1,0,0,0,0,0), mk(1,0,0,0,0,0)};

        do_reset();
        check_cnt("reset_cnt", 0);
        step("reset_outputs", idle, mk(1,0,0,0,0,0));

        for (int i = 0; i < 12; i++) begin
            do_reset();
`ifdef FORWARDING_EN
            step(vecs[i].name, vecs[i].in, vecs[i].exp_fw);
`else
            step(vecs[i].name, vecs[i].in, vecs[i].exp_nf);
`endif
        end

        // Main stall sequence: load-use with forwarding, two-cycle RAW without.
        do_reset();
        step("stall_c1", haz, mk(0,0,1,0,0,0));
`ifndef FORWARDING_EN
        step("stall_c2", haz, mk(0,0,1,1,0,0));
`endif
        step("stall_release", idle, mk(1,0,0,0,0,0));
`ifdef FORWARDING_EN
        check_cnt("stall_count", 1);
`else
        check_cnt("stall_count", 2);
`endif

        // Branch against a stall: mid-STALL without forwarding, same-cycle with it.
        do_reset();
`ifdef FORWARDING_EN
        step("br_over_haz", haz_br, mk(1,1,1,0,0,0));
        step("br_after", idle, mk(1,0,0,0,0,0));
        check_cnt("br_count", 0);
`else
        step("br_pre", haz, mk(0,0,1,0,0,0));
        step("br_in_stall", haz_br, mk(1,1,1,1,0,0));
        step("br_after", idle, mk(1,0,0,0,0,0));
        check_cnt("br_count", 1);
`endif

        // Synchronous reset while a stall is in progress.
        do_reset();
        step("rst_pre", haz, mk(0,0,1,0,0,0));
        reset = 1'b1;
`ifdef FORWARDING_EN
        step("rst_cycle", haz, mk(0,0,1,0,0,0));
`else
        step("rst_cycle", haz, mk(0,0,1,1,0,0));
`endif
        reset = 1'b0;
        step("rst_after", idle, mk(1,0,0,0,0,0));
        check_cnt("rst_count", 0);

        // Continuous hazard drives the narrow counter into saturation.
        do_reset();
        apply(haz);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check_cnt("sat_hold", 7);
        @(posedge clk);
        #1;
        check_cnt("sat_nowrap", 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
